// File: rtl/if_pkg.sv
//==============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the Thumb-16 instruction fetch
//               stage: the prefetch entry layout and the fetch FSM states.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package if_pkg;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    typedef struct packed {
        logic [15:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } if_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//==============================================================================
// Module      : fetch_fifo
// Description : Prefetch buffer holding fetched halfwords with their byte PCs.
//               Power-of-two depth, naturally wrapping pointers, single-cycle flush.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (PTR_W+1)'(DEPTH));
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only observed through the count.
    always_ff @(posedge clock) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
//==============================================================================
// Module      : instruction_fetch
// Description : Owns the fetch PC, issues halfword reads on granted memory
//               cycles and feeds the decoder from the prefetch buffer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instruction_fetch
    import if_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] RESET_PC   = c_reset_pc
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall_from_decode,
    input  logic                  decoder_pc_update,
    input  logic [31:0]           RF_pc_out,
    input  logic                  mem_grant,
    input  logic [15:0]           mem_data,
    output logic                  mem_enable,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [15:0]           instruction,
    output logic                  instruction_valid,
    output logic                  stall_to_decode,
    output logic [31:0]           fetch_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if_state_t      r_state;
    if_state_t      w_state_next;
    logic [31:0]    r_pc;
    logic [31:0]    r_issued_pc;
    logic           r_pending;

    logic [31:0]    w_target;
    logic [31:0]    w_issue_pc;
    logic [31:0]    w_pc_next;
    logic           w_issue;
    logic           w_credit;
    logic           w_push;
    logic           w_pop;
    logic [PTR_W:0]   w_count;
    logic [PTR_W+1:0] w_inflight;
    logic           w_empty;
    logic           w_full;
    fetch_entry_t   w_head;
    fetch_entry_t   w_push_entry;

    assign w_target   = RF_pc_out & ~32'd1;
    assign w_issue_pc = decoder_pc_update ? w_target : r_pc;
    assign w_pc_next  = w_issue ? (w_issue_pc + 32'd2) : w_issue_pc;

    // Credits count the read in flight so a returning halfword always has a slot.
    // A redirect flushes the buffer and drops the in-flight response, so it
    // frees every slot for the redirected read.
    assign w_inflight = {1'b0, w_count} + (PTR_W+2)'(r_pending);
    assign w_credit   = decoder_pc_update
                     || (!w_full && (w_inflight < (PTR_W+2)'(FIFO_DEPTH)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end
            RUN: begin
                w_issue = mem_grant && w_credit;
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_pending   <= 1'b0;
            r_issued_pc <= '0;
        end else begin
            r_pc      <= w_pc_next;
            r_pending <= w_issue;
            if (w_issue) begin
                r_issued_pc <= w_issue_pc;
            end
        end
    end

    assign mem_enable      = w_issue;
    assign mem_read_enable = w_issue;
    assign mem_address     = w_issue ? w_issue_pc[ADDR_WIDTH:1] : '0;

    assign w_push             = r_pending && !decoder_pc_update;
    assign w_pop              = !w_empty && !stall_from_decode && !decoder_pc_update;
    assign w_push_entry.instr = mem_data;
    assign w_push_entry.pc    = r_issued_pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (decoder_pc_update),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign instruction_valid = !w_empty;
    assign stall_to_decode   = w_empty;
    assign instruction       = w_empty ? 16'h0000 : w_head.instr;
    assign fetch_pc          = w_empty ? 32'h0000_0000 : w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
//==============================================================================
// Module      : tb_instruction_fetch
// Description : Scoreboard bench for instruction_fetch with a synchronous
//               halfword memory model and cycle-accurate spot checks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instruction_fetch;
    import if_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall_from_decode = 1'b0;
    logic        decoder_pc_update = 1'b0;
    logic [31:0] RF_pc_out = 32'h0;
    logic        mem_grant = 1'b1;
    logic [15:0] mem_data = 16'h0;
    logic        mem_enable;
    logic        mem_read_enable;
    logic [11:0] mem_address;
    logic [15:0] instruction;
    logic        instruction_valid;
    logic        stall_to_decode;
    logic [31:0] fetch_pc;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_pops = 0;
    fetch_entry_t sb[$];

    instruction_fetch #(
        .FIFO_DEPTH (4),
        .ADDR_WIDTH (12),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .stall_from_decode (stall_from_decode),
        .decoder_pc_update (decoder_pc_update),
        .RF_pc_out         (RF_pc_out),
        .mem_grant         (mem_grant),
        .mem_data          (mem_data),
        .mem_enable        (mem_enable),
        .mem_read_enable   (mem_read_enable),
        .mem_address       (mem_address),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .stall_to_decode   (stall_to_decode),
        .fetch_pc          (fetch_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        case (a)
            12'd0:   return 16'h2005;
            12'd1:   return 16'h210a;
            12'd2:   return 16'h220f;
            12'd3:   return 16'h2314;
            default: return {4'hA, a};
        endcase
    endfunction

    always @(posedge clock) begin
        if (mem_enable && mem_read_enable) begin
            mem_data <= mem_word(mem_address);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        logic [31:0] p;
        fetch_entry_t e;
        sb.delete();
        p = start & ~32'd1;
        for (int i = 0; i < 64; i++) begin
            e.instr = mem_word(p[12:1]);
            e.pc    = p;
            sb.push_back(e);
            p = p + 32'd2;
        end
    endtask

    // Decoder side: every accepted instruction must be the next one in program order.
    always @(negedge clock) begin
        if (reset && instruction_valid && !stall_from_decode && !decoder_pc_update) begin
            n_pops++;
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                check_eq("sb_instr", {16'h0, instruction}, {16'h0, sb[0].instr});
                check_eq("sb_pc", fetch_pc, sb[0].pc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        int target;
        target = n_pops + n;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            if (n_pops >= target) break;
        end
        check_eq(tag, 32'(n_pops >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_en"},    32'(mem_enable), 32'd0);
        check_eq({tag, "_rd"},    32'(mem_read_enable), 32'd0);
        check_eq({tag, "_addr"},  32'(mem_address), 32'd0);
        check_eq({tag, "_valid"}, 32'(instruction_valid), 32'd0);
        check_eq({tag, "_instr"}, 32'(instruction), 32'd0);
        check_eq({tag, "_pc"},    fetch_pc, 32'd0);
        check_eq({tag, "_stall"}, 32'(stall_to_decode), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_reads;

        // 1: boot, latency and streaming
        step(); step();
        check_reset_outputs("rst0");
        step(); reset = 1'b1; sb_restart(32'h0); #1;
        check_eq("t1_boot_en", 32'(mem_enable), 32'd0);
        step(); #1;
        check_eq("t1_first_en", 32'(mem_enable), 32'd1);
        check_eq("t1_first_rd", 32'(mem_read_enable), 32'd1);
        check_eq("t1_first_addr", 32'(mem_address), 32'h000);
        step(); #1;
        check_eq("t1_lat_nvalid", 32'(instruction_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            check_eq("t1_valid", 32'(instruction_valid), 32'd1);
            check_eq("t1_pc", fetch_pc, 32'(2 * i));
            check_eq("t1_instr", 32'(instruction), 32'(mem_word(12'(i))));
        end

        // 2: decoder stall fills the buffer, then drains in order
        step(); reset = 1'b0; stall_from_decode = 1'b1; #1;
        check_reset_outputs("rst1");
        step(); reset = 1'b1; sb_restart(32'h0); #1;
        check_eq("t2_boot_en", 32'(mem_enable), 32'd0);
        n_reads = 0;
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            if (mem_enable) n_reads++;
        end
        check_eq("t2_reads", 32'(n_reads), 32'd4);
        check_eq("t2_full_en", 32'(mem_enable), 32'd0);
        check_eq("t2_head", 32'(instruction), 32'h2005);
        step(); stall_from_decode = 1'b0;
        wait_pops("t2_drain", 6, 30);

        // 3: redirect with reads in flight
        step(); decoder_pc_update = 1'b1; RF_pc_out = 32'h0000_0011; sb_restart(32'h11); #1;
        check_eq("t3_r_en", 32'(mem_enable), 32'd1);
        check_eq("t3_r_addr", 32'(mem_address), 32'h008);
        step(); decoder_pc_update = 1'b0; #1;
        check_eq("t3_flushed", 32'(instruction_valid), 32'd0);
        check_eq("t3_addr1", 32'(mem_address), 32'h009);
        step(); #1;
        check_eq("t3_valid", 32'(instruction_valid), 32'd1);
        check_eq("t3_pc", fetch_pc, 32'h10);
        check_eq("t3_instr", 32'(instruction), 32'(mem_word(12'h008)));

        // 4: grant withdrawn for three cycles
        for (int i = 0; i < 3; i++) begin
            step(); mem_grant = 1'b0; #1;
            check_eq("t4_nogrant_en", 32'(mem_enable), 32'd0);
        end
        step(); mem_grant = 1'b1; #1;
        check_eq("t4_resume_en", 32'(mem_enable), 32'd1);
        check_eq("t4_resume_addr", 32'(mem_address), 32'h00B);
        wait_pops("t4_stream", 6, 30);

        // 5: address wrap at the top of the memory port
        step(); decoder_pc_update = 1'b1; RF_pc_out = 32'h0000_1FFE; sb_restart(32'h1FFE); #1;
        check_eq("t5_addr_top", 32'(mem_address), 32'hFFF);
        step(); decoder_pc_update = 1'b0; #1;
        check_eq("t5_addr_wrap", 32'(mem_address), 32'h000);
        step(); #1;
        check_eq("t5_pc0", fetch_pc, 32'h1FFE);
        check_eq("t5_instr0", 32'(instruction), 32'(mem_word(12'hFFF)));
        step(); #1;
        check_eq("t5_pc1", fetch_pc, 32'h2000);
        check_eq("t5_instr1", 32'(instruction), 32'h2005);

        // 6: asynchronous reset in the middle of a burst
        step(); stall_from_decode = 1'b1;
        step(); step();
        step(); reset = 1'b0; #1;
        check_reset_outputs("rst2");
        step(); reset = 1'b1; stall_from_decode = 1'b0; sb_restart(32'h0); #1;
        check_eq("t6_boot_en", 32'(mem_enable), 32'd0);
        step(); #1;
        check_eq("t6_first_en", 32'(mem_enable), 32'd1);
        check_eq("t6_first_addr", 32'(mem_address), 32'h000);
        step(); step(); #1;
        check_eq("t6_pc", fetch_pc, 32'h0);
        wait_pops("t6_stream", 4, 20);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Upstream neighbour of the decode stage in the Thumb-16 core. It owns the fetch PC and issues halfword reads to the shared 16-bit memory port whenever the memory controller grants it. Returned halfwords are buffered in a small prefetch FIFO, which feeds the decoder through a valid/stall handshake. It also accepts PC redirects (branches) from decode and flushes stale fetches.

Parameters:
FIFO_DEPTH, 4, prefetch buffer entries (power of two, >=2)
ADDR_WIDTH, 12, halfword address width of the memory port
RESET_PC, 32'h0000_0000, byte address fetched first after reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
stall_from_decode  input  1  decoder cannot accept this cycle (decode's stall_to_instructionfetch)
decoder_pc_update  input  1  redirect request from decode
RF_pc_out  input  32  redirect target byte address, valid with decoder_pc_update
mem_grant  input  1  memory port free for fetch this cycle (controller not doing a data access)
mem_data  input  16  read data; synchronous memory, valid the cycle after a read
mem_enable  output  1  memory enable
mem_read_enable  output  1  read strobe
mem_address  output  ADDR_WIDTH  halfword address = pc[ADDR_WIDTH:1]
instruction  output  16  FIFO head halfword; 16'h0000 when not valid
instruction_valid  output  1  head entry valid
stall_to_decode  output  1  equals !instruction_valid (decode's stall_from_instructionfetch)
fetch_pc  output  32  byte address of the presented instruction; 0 when not valid

Behaviour:
- Reset (reset=0, async): state=BOOT, fetch PC=RESET_PC, FIFO empty, pending=0. All outputs are 0, and stall_to_decode=1.
- FSM BOOT: one cycle after reset release with no request (memory preload window), then RUN. Redirects in BOOT are honoured (they load the PC).
- RUN issue condition: mem_grant && (count + pending < FIFO_DEPTH). Issue drives mem_enable=mem_read_enable=1 and mem_address from the fetch PC, sets pending, and advances PC by 2. Outputs are combinational from state and mem_grant.
- Response: in the cycle after an issue, if pending && !decoder_pc_update, {mem_data, issued_pc} is pushed into the FIFO. pending is cleared unless a new issue occurs.
- Latency: issue at cycle N, data pushed at N+1, visible at the head at N+2. There is no bypass.
- Pop: the head is consumed when instruction_valid && !stall_from_decode. Push and pop in the same cycle are allowed; count is unchanged.
- Full: no issue. Since the credit check includes the pending read, there is never a push into a full FIFO.
- Empty: instruction_valid=0 and stall_to_decode=1.
- Redirect (decoder_pc_update=1 in cycle R):
  - FIFO cleared at the R edge.
  - Any response returning in R is discarded.
  - The target address is RF_pc_out & ~1, and the issue in R uses it directly when mem_grant.
  - The PC becomes target+2 on issue, or target otherwise.
  - The first redirected instruction is valid at R+2 at the earliest.
  - A redirect overrides any simultaneous pop.
- Grant low: no issue, and the PC holds. A pending response is still captured (the grant applies only to new requests).
- Wrap: the PC is 32-bit and increments by 2 mod 2^32. mem_address truncates, so it wraps from 0xFFF to 0x000.
- FIFO pointers: log2(FIFO_DEPTH) bits wrapping naturally; count has log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package if_pkg holds:
  - typedef fetch_entry_t {logic [15:0] instr; logic [31:0] pc;}
  - typedef enum {BOOT, RUN} if_state_t
  - RESET_PC default
- Sub-module fetch_fifo (parameterised depth, entry type fetch_entry_t) with push, pop, flush, count, head, and empty/full flags.
- instruction_fetch contains the FSM, PC register, pending flag, credit logic and output muxing.

Test Plan:
1. Preload halfwords 0..3 = 2005,210a,220f,2314 and release reset with grant=1 and no stall. Required: BOOT 1 cycle, first read of addr 0 in the next cycle, 2005 valid with fetch_pc=0 two cycles later, then one instruction per cycle with fetch_pc 0,2,4,6.
2. Hold stall_from_decode=1 for 10 cycles. Required: exactly 4 reads are issued, then mem_enable=0, and the head remains 2005. After stall release, 2005,210a,220f,2314 are delivered in order with no loss or duplicates.
3. Issue a redirect to RF_pc_out=0x0000_0011 while reads are in flight. Required: the in-flight response is dropped, the FIFO is flushed, mem_address=0x008 in the redirect cycle, and the next valid instruction has fetch_pc=0x10 two cycles later.
4. Drop mem_grant low for 3 cycles mid-stream. Required: no issue and PC held; the pending response is still pushed; fetching resumes seamlessly.
5. Redirect to 0x1FFE with grant=1. Required: addresses 0xFFF then 0x000; fetch_pc values 0x1FFE then 0x2000.
6. Assert reset low mid-burst with a pending read and full FIFO. Required: outputs are immediately 0, stall_to_decode=1, and after release fetching restarts at RESET_PC.
